// File: rtl/timer_slave_pkg.sv
// Shared definitions for the RIB timer slave: bus types, register offsets,
// CTRL field layout and small helpers used by the top level.
package timer_slave_pkg;

  // Data and address widths of the RIB peripheral bus.
  localparam int MEM_BUS_W      = 32;
  localparam int MEM_ADDR_BUS_W = 32;

  typedef logic [MEM_BUS_W-1:0]      MemBus;
  typedef logic [MEM_ADDR_BUS_W-1:0] MemAddrBus;

  // Word offsets decoded from addr[3:2].
  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_COUNT  = 2'd1;
  localparam logic [1:0] TIMER_CMP    = 2'd2;
  localparam logic [1:0] TIMER_STATUS = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;
  localparam int CTRL_AR_BIT = 2;

  // STATUS bit positions.
  localparam int STATUS_PEND_BIT = 0;

  // CTRL register contents; field order puts EN at bit0, IE at bit1, AR at bit2.
  typedef struct packed {
    logic ar;
    logic ie;
    logic en;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{ar: 1'b0, ie: 1'b0, en: 1'b0};

  // Extract the implemented CTRL fields from a bus write word; upper bits dropped.
  function automatic ctrl_t ctrl_from_word(input MemBus word);
    ctrl_t c;
    c.en = word[CTRL_EN_BIT];
    c.ie = word[CTRL_IE_BIT];
    c.ar = word[CTRL_AR_BIT];
    return c;
  endfunction

  // Present CTRL as a bus read word with unimplemented bits reading zero.
  function automatic MemBus ctrl_to_word(input ctrl_t c);
    MemBus w;
    w = 32'h0000_0000;
    w[CTRL_EN_BIT] = c.en;
    w[CTRL_IE_BIT] = c.ie;
    w[CTRL_AR_BIT] = c.ar;
    return w;
  endfunction

  // Present STATUS as a bus read word; only PEND is implemented.
  function automatic MemBus status_to_word(input logic pend);
    MemBus w;
    w = 32'h0000_0000;
    w[STATUS_PEND_BIT] = pend;
    return w;
  endfunction

endpackage

// File: rtl/timer_slave_prescaler.sv
// Clock prescaler for the timer: produces a one-cycle tick every PRESCALE
// clock cycles while enabled, and parks at zero while disabled.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic en_i,
  output logic tick_o
);

  // Counter width covers 0..PRESCALE-1; a single bit is kept for PRESCALE=1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          at_last_s;

  assign at_last_s = (cnt_q == LAST);

  // The tick is asserted during the cycle the counter sits on its last value.
  assign tick_o = en_i & at_last_s;

  // Next prescaler value: hold at zero when disabled, wrap after the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (at_last_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_slave.sv
// Memory-mapped 32-bit timer on the RIB peripheral bus. Zero-wait-state
// register file (CTRL, COUNT, CMP, STATUS), prescaled up-counter with
// compare match, one-shot or periodic mode, and a level interrupt.
module timer_slave
  import timer_slave_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter logic [31:0] CMP_RST  = 32'hFFFF_FFFF
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      req_i,
  input  logic      we_i,
  input  MemAddrBus addr_i,
  input  MemBus     data_i,
  output MemBus     data_o,
  output logic      int_o
);

  // Architectural state.
  ctrl_t ctrl_q, ctrl_d;
  MemBus count_q, count_d;
  MemBus cmp_q, cmp_d;
  logic  pend_q, pend_d;

  // Decode and datapath signals.
  logic [1:0] sel_s;
  logic       wr_s;
  logic       wr_ctrl_s;
  logic       wr_count_s;
  logic       wr_cmp_s;
  logic       wr_status_s;
  logic       rd_s;
  logic       tick_s;
  logic       eff_tick_s;
  logic       match_s;
  MemBus      rd_data_s;
  logic       unused_addr_s;

  // Only addr[3:2] selects a register; the remaining address bits are don't-care.
  assign sel_s         = addr_i[3:2];
  assign unused_addr_s = ^{addr_i[31:4], addr_i[1:0]};

  assign wr_s        = req_i & we_i;
  assign rd_s        = req_i & ~we_i;
  assign wr_ctrl_s   = wr_s & (sel_s == TIMER_CTRL);
  assign wr_count_s  = wr_s & (sel_s == TIMER_COUNT);
  assign wr_cmp_s    = wr_s & (sel_s == TIMER_CMP);
  assign wr_status_s = wr_s & (sel_s == TIMER_STATUS);

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (ctrl_q.en),
    .tick_o (tick_s)
  );

  // A software write to COUNT overrides a coincident tick, so that tick
  // neither advances the counter nor produces a match. The compare uses the
  // CMP value registered before this edge, so a CMP write applies next time.
  assign eff_tick_s = tick_s & ~wr_count_s;
  assign match_s    = eff_tick_s & (count_q == cmp_q);

  // Next-state for CTRL: software write beats the one-shot auto-clear of EN.
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl_s) begin
      ctrl_d = ctrl_from_word(data_i);
    end else if (match_s && !ctrl_q.ar) begin
      ctrl_d.en = 1'b0;
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Next-state for COUNT: software write, then reload/hold on match, then increment.
  always_comb begin
    count_d = count_q;
    if (wr_count_s) begin
      count_d = data_i;
    end else if (match_s) begin
      if (ctrl_q.ar) begin
        count_d = 32'h0000_0000;
      end else begin
        count_d = count_q;
      end
    end else if (eff_tick_s) begin
      count_d = count_q + 32'h0000_0001;
    end else begin
      count_d = count_q;
    end
  end

  // Next-state for CMP: plain software-written register.
  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp_s) begin
      cmp_d = data_i;
    end else begin
      cmp_d = cmp_q;
    end
  end

  // Next-state for PEND: a new match sets it and beats a coincident W1C.
  always_comb begin
    pend_d = pend_q;
    if (match_s) begin
      pend_d = 1'b1;
    end else if (wr_status_s && data_i[STATUS_PEND_BIT]) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Register file update; reset returns every register to its power-on value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q  <= CTRL_RST;
      count_q <= 32'h0000_0000;
      cmp_q   <= CMP_RST;
      pend_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
    end
  end

  // Read mux: combinational select of the addressed register.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (sel_s)
      TIMER_CTRL:   rd_data_s = ctrl_to_word(ctrl_q);
      TIMER_COUNT:  rd_data_s = count_q;
      TIMER_CMP:    rd_data_s = cmp_q;
      TIMER_STATUS: rd_data_s = status_to_word(pend_q);
      default:      rd_data_s = 32'h0000_0000;
    endcase
  end

  // The bus only sees read data during a read request; otherwise it is zero.
  assign data_o = rd_s ? rd_data_s : 32'h0000_0000;

  // Level interrupt straight from the registered PEND and IE bits.
  assign int_o = pend_q & ctrl_q.ie;

endmodule

// File: tb/tb_timer_slave.sv
// Directed, scoreboard-checked bench for timer_slave. Two instances share the
// clock and reset: one with PRESCALE=1 and one with PRESCALE=4.
module tb_timer_slave;

  logic        clk;
  logic        rstn;
  logic        we;
  logic        req1;
  logic        req4;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] data1;
  logic [31:0] data4;
  logic        int1;
  logic        int4;

  int vectors;
  int miscompares;

  logic [31:0] exp_q[$];

  localparam logic [31:0] A_CTRL   = 32'h0000_0000;
  localparam logic [31:0] A_COUNT  = 32'h0000_0004;
  localparam logic [31:0] A_CMP    = 32'h0000_0008;
  localparam logic [31:0] A_STATUS = 32'h0000_000C;

  timer_slave #(.PRESCALE(1)) dut1 (
    .clk    (clk),
    .rstn   (rstn),
    .req_i  (req1),
    .we_i   (we),
    .addr_i (addr),
    .data_i (wdata),
    .data_o (data1),
    .int_o  (int1)
  );

  timer_slave #(.PRESCALE(4)) dut4 (
    .clk    (clk),
    .rstn   (rstn),
    .req_i  (req4),
    .we_i   (we),
    .addr_i (addr),
    .data_i (wdata),
    .data_o (data4),
    .int_o  (int4)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic compare(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = exp_q.pop_front();
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, e);
    end
  endtask

  // One write, committed at the next rising edge.
  task automatic wr(input bit sel4, input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    if (sel4) req4 = 1'b1; else req1 = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0; req4 = 1'b0; we = 1'b0;
  endtask

  // Zero-wait read inside the current cycle; no clock edge is consumed.
  task automatic rd(input bit sel4, input logic [31:0] a, input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    we = 1'b0; addr = a;
    if (sel4) req4 = 1'b1; else req1 = 1'b1;
    #1;
    compare(tag, sel4 ? data4 : data1);
    req1 = 1'b0; req4 = 1'b0;
  endtask

  // Check the interrupt line of one instance.
  task automatic chk_int(input bit sel4, input logic e, input string tag);
    exp_q.push_back({31'd0, e});
    #1;
    compare(tag, {31'd0, sel4 ? int4 : int1});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rstn = 1'b0; we = 1'b0; req1 = 1'b0; req4 = 1'b0;
    addr = 32'h0; wdata = 32'h0;

    // Reset state
    #3;
    chk_int(0, 1'b0, "rst_int1");
    exp_q.push_back(32'h0);
    #1 compare("rst_data_idle", data1);
    @(negedge clk);
    rstn = 1'b1;
    idle(1);
    rd(0, A_CMP,    32'hFFFF_FFFF, "rst_cmp");
    rd(0, A_COUNT,  32'h0,         "rst_count");
    rd(0, A_CTRL,   32'h0,         "rst_ctrl");
    rd(0, A_STATUS, 32'h0,         "rst_status");

    // One-shot, PRESCALE=1, CMP=5, CTRL=EN|IE
    wr(0, A_CMP, 32'd5);
    wr(0, A_CTRL, 32'h3);
    rd(0, A_COUNT, 32'd0, "os_count0");
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      rd(0, A_COUNT, k, "os_step");
      rd(0, A_STATUS, 32'h0, "os_pend0");
    end
    chk_int(0, 1'b0, "os_int_before");
    idle(1);
    chk_int(0, 1'b1, "os_int_after");
    rd(0, A_STATUS, 32'h1, "os_pend1");
    rd(0, A_CTRL,   32'h2, "os_ctrl_autoclr");
    rd(0, A_COUNT,  32'd5, "os_count_hold");
    idle(2);
    rd(0, A_COUNT,  32'd5, "os_count_hold2");

    // W1C clears PEND and the interrupt
    wr(0, A_STATUS, 32'h1);
    rd(0, A_STATUS, 32'h0, "w1c_pend");
    chk_int(0, 1'b0, "w1c_int");

    // Set beats clear: W1C on the match edge
    wr(0, A_COUNT, 32'd0);
    wr(0, A_CMP, 32'd3);
    wr(0, A_CTRL, 32'h7);
    idle(3);
    rd(0, A_COUNT,  32'd3, "sbc_count3");
    rd(0, A_STATUS, 32'h0, "sbc_pend_pre");
    wr(0, A_STATUS, 32'h1);
    rd(0, A_STATUS, 32'h1, "sbc_pend_kept");
    rd(0, A_COUNT,  32'd0, "sbc_reload");
    chk_int(0, 1'b1, "sbc_int");
    wr(0, A_STATUS, 32'h1);
    rd(0, A_STATUS, 32'h0, "sbc_pend_clr");
    rd(0, A_COUNT,  32'd1, "sbc_count1");
    wr(0, A_CTRL, 32'h0);

    // Wrap past 0xFFFF_FFFF, one-shot with IE=0
    wr(0, A_COUNT, 32'hFFFF_FFFE);
    wr(0, A_CMP, 32'd1);
    wr(0, A_CTRL, 32'h1);
    rd(0, A_COUNT, 32'hFFFF_FFFE, "wrap_fe");
    idle(1); rd(0, A_COUNT, 32'hFFFF_FFFF, "wrap_ff");
    idle(1); rd(0, A_COUNT, 32'h0, "wrap_0");
    idle(1); rd(0, A_COUNT, 32'h1, "wrap_1");
    rd(0, A_STATUS, 32'h0, "wrap_pend0");
    idle(1);
    rd(0, A_STATUS, 32'h1, "wrap_pend1");
    rd(0, A_COUNT,  32'h1, "wrap_hold");
    rd(0, A_CTRL,   32'h0, "wrap_ctrl");
    chk_int(0, 1'b0, "wrap_int_masked");

    // Bus priority and decode
    wr(0, A_STATUS, 32'h1);
    wr(0, A_CMP, 32'd1000);
    wr(0, A_CTRL, 32'h1);
    idle(3);
    wr(0, A_COUNT, 32'd100);
    rd(0, A_COUNT, 32'd100, "prio_count");
    idle(1);
    rd(0, A_COUNT, 32'd101, "prio_count_inc");
    exp_q.push_back(32'h0);
    we = 1'b0; addr = A_CMP; req1 = 1'b0;
    #1 compare("noreq_data", data1);
    rd(0, 32'h1000_0008, 32'd1000, "alias_cmp");
    wr(0, A_CTRL, 32'hFFFF_FFF8);
    rd(0, A_CTRL, 32'h0, "ctrl_upper_ignored");
    idle(1);
    rd(0, A_COUNT, 32'd102, "en0_hold");

    // Periodic, PRESCALE=4, CMP=2, CTRL=EN|IE|AR
    wr(1, A_CMP, 32'd2);
    wr(1, A_CTRL, 32'h7);
    rd(1, A_COUNT, 32'd0, "per_c0");
    idle(3); rd(1, A_COUNT, 32'd0, "per_c0_late");
    idle(1); rd(1, A_COUNT, 32'd1, "per_c1");
    idle(4); rd(1, A_COUNT, 32'd2, "per_c2");
    rd(1, A_STATUS, 32'h0, "per_pend0");
    idle(3); rd(1, A_STATUS, 32'h0, "per_pend0_late");
    idle(1);
    rd(1, A_COUNT,  32'd0, "per_reload");
    rd(1, A_STATUS, 32'h1, "per_pend1");
    chk_int(1, 1'b1, "per_int1");
    idle(12);
    rd(1, A_COUNT,  32'd0, "per_reload2");
    rd(1, A_STATUS, 32'h1, "per_pend_sticky");
    wr(1, A_STATUS, 32'h1);
    chk_int(1, 1'b0, "per_int_w1c");
    rd(1, A_STATUS, 32'h0, "per_pend_w1c");
    idle(11);
    rd(1, A_STATUS, 32'h1, "per_pend_again");
    wr(1, A_STATUS, 32'h0);
    rd(1, A_STATUS, 32'h1, "per_w0_noeffect");
    chk_int(1, 1'b1, "per_int_pre_rst");

    // Reset mid-count with PEND=1
    #2 rstn = 1'b0;
    chk_int(1, 1'b0, "rst_mid_int");
    rd(1, A_STATUS, 32'h0, "rst_mid_pend");
    @(negedge clk);
    rstn = 1'b1;
    idle(1);
    rd(1, A_CMP,    32'hFFFF_FFFF, "rst2_cmp");
    rd(1, A_COUNT,  32'h0,         "rst2_count");
    rd(1, A_CTRL,   32'h0,         "rst2_ctrl");
    rd(1, A_STATUS, 32'h0,         "rst2_status");
    idle(5);
    rd(1, A_COUNT,  32'h0,         "rst2_count_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
